// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I(M) opcode, funct3, ALU/compare and control bundle types
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    f3_beq = 3'b000, f3_bne = 3'b001, f3_blt = 3'b100,
    f3_bge = 3'b101, f3_bltu = 3'b110, f3_bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_lb = 3'b000, f3_lh = 3'b001, f3_lw = 3'b010, f3_lbu = 3'b100, f3_lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'b000, f3_sh = 3'b001, f3_sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    f3_add = 3'b000, f3_sll = 3'b001, f3_slt = 3'b010, f3_sltu = 3'b011,
    f3_xor = 3'b100, f3_sr  = 3'b101, f3_or  = 3'b110, f3_and  = 3'b111
  } arith_funct3_t;

  typedef union packed {
    branch_funct3_t branch;
    load_funct3_t   load;
    store_funct3_t  store;
    arith_funct3_t  arith;
  } funct3_t;

  // M-extension ops occupy the upper half so funct3 maps directly onto them
  typedef enum logic [3:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and,
    alu_mul, alu_mulh, alu_mulhsu, alu_mulhu, alu_div, alu_divu, alu_rem, alu_remu
  } alu_ops_t;

  typedef enum logic [2:0] {
    cmp_eq = 3'b000, cmp_ne = 3'b001, cmp_lt = 3'b100,
    cmp_ge = 3'b101, cmp_ltu = 3'b110, cmp_geu = 3'b111
  } cmp_ops_t;

  typedef enum logic {rs1_out, pc_out} alumux1_sel_t;
  typedef enum logic [2:0] {i_imm, u_imm, b_imm, s_imm, j_imm, rs2_out} alumux2_sel_t;
  typedef enum logic {cmp_rs2, cmp_i_imm} cmpmux_sel_t;
  typedef enum logic [2:0] {rf_alu_out, rf_br_en, rf_u_imm, rf_load, rf_pc_plus4} regfilemux_sel_t;

  typedef struct packed {
    logic            valid_rvfi;
    alu_ops_t        aluop;
    cmp_ops_t        cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            load_reg;
    logic            mem_read;
    logic            mem_write;
    load_funct3_t    load_align;
    store_funct3_t   store_size;
    logic            is_branch;
    logic            is_jump;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } control_signals_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic control_signals_t ctrl_defaults();
    control_signals_t c;
    c                = '0;
    c.aluop          = alu_add;
    c.cmpop          = cmp_eq;
    c.alumux1_sel    = rs1_out;
    c.alumux2_sel    = i_imm;
    c.cmpmux_sel     = cmp_rs2;
    c.regfilemux_sel = rf_alu_out;
    c.load_align     = f3_lb;
    c.store_size     = f3_sb;
    return c;
  endfunction

  // alt selects sub/sra; callers decide whether bit 30 is meaningful
  function automatic alu_ops_t arith_aluop(arith_funct3_t f, logic alt);
    alu_ops_t op;
    case (f)
      f3_add:  op = alt ? alu_sub : alu_add;
      f3_sll:  op = alu_sll;
      f3_xor:  op = alu_xor;
      f3_sr:   op = alt ? alu_sra : alu_srl;
      f3_or:   op = alu_or;
      f3_and:  op = alu_and;
      default: op = alu_add;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - combinational RV32I decoder; RV32M_EN adds mul/div decode
module inst_decode
  import rv32i_types::*;
(
  input  logic [31:0]      inst,
  input  logic [31:0]      pc,
  output control_signals_t ctrl,
  output logic             illegal,
  output logic             multicycle
);

  logic [6:0] funct7;
  funct3_t    f3;
  logic       unused_pc;

  assign funct7    = inst[31:25];
  assign f3        = inst[14:12];
  assign unused_pc = ^pc;

  always_comb begin
    ctrl       = ctrl_defaults();
    illegal    = 1'b0;
    multicycle = 1'b0;
    ctrl.rd    = inst[11:7];
    ctrl.rs1   = inst[19:15];
    ctrl.rs2   = inst[24:20];
    case (inst[6:0])
      op_lui: begin
        ctrl.load_reg       = 1'b1;
        ctrl.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        ctrl.alumux1_sel = pc_out;
        ctrl.alumux2_sel = u_imm;
        ctrl.load_reg    = 1'b1;
      end
      op_jal: begin
        ctrl.alumux1_sel    = pc_out;
        ctrl.alumux2_sel    = j_imm;
        ctrl.regfilemux_sel = rf_pc_plus4;
        ctrl.load_reg       = 1'b1;
        ctrl.is_jump        = 1'b1;
      end
      op_jalr: begin
        ctrl.regfilemux_sel = rf_pc_plus4;
        ctrl.load_reg       = 1'b1;
        ctrl.is_jump        = 1'b1;
      end
      op_br: begin
        ctrl.alumux1_sel = pc_out;
        ctrl.alumux2_sel = b_imm;
        ctrl.is_branch   = 1'b1;
        case (f3.branch)
          f3_beq:  ctrl.cmpop = cmp_eq;
          f3_bne:  ctrl.cmpop = cmp_ne;
          f3_blt:  ctrl.cmpop = cmp_lt;
          f3_bge:  ctrl.cmpop = cmp_ge;
          f3_bltu: ctrl.cmpop = cmp_ltu;
          f3_bgeu: ctrl.cmpop = cmp_geu;
          default: illegal = 1'b1;
        endcase
      end
      op_load: begin
        ctrl.mem_read       = 1'b1;
        ctrl.load_reg       = 1'b1;
        ctrl.regfilemux_sel = rf_load;
        case (f3.load)
          f3_lb, f3_lh, f3_lw, f3_lbu, f3_lhu: ctrl.load_align = f3.load;
          default: illegal = 1'b1;
        endcase
      end
      op_store: begin
        ctrl.alumux2_sel = s_imm;
        ctrl.mem_write   = 1'b1;
        case (f3.store)
          f3_sb, f3_sh, f3_sw: ctrl.store_size = f3.store;
          default: illegal = 1'b1;
        endcase
      end
      op_imm: begin
        ctrl.load_reg = 1'b1;
        ctrl.aluop    = arith_aluop(f3.arith, (f3.arith == f3_sr) && inst[30]);
        case (f3.arith)
          f3_slt: begin
            ctrl.cmpop          = cmp_lt;
            ctrl.cmpmux_sel     = cmp_i_imm;
            ctrl.regfilemux_sel = rf_br_en;
          end
          f3_sltu: begin
            ctrl.cmpop          = cmp_ltu;
            ctrl.cmpmux_sel     = cmp_i_imm;
            ctrl.regfilemux_sel = rf_br_en;
          end
          f3_sll:  illegal = (funct7 != 7'b0000000);
          f3_sr:   illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          default: ;
        endcase
      end
      op_reg: begin
        ctrl.alumux2_sel = rs2_out;
        ctrl.load_reg    = 1'b1;
        case (funct7)
          7'b0000000, 7'b0100000: begin
            ctrl.aluop = arith_aluop(f3.arith, inst[30]);
            case (f3.arith)
              f3_slt: begin
                ctrl.cmpop          = cmp_lt;
                ctrl.regfilemux_sel = rf_br_en;
              end
              f3_sltu: begin
                ctrl.cmpop          = cmp_ltu;
                ctrl.regfilemux_sel = rf_br_en;
              end
              default: ;
            endcase
            if (inst[30] && (f3.arith != f3_add) && (f3.arith != f3_sr))
              illegal = 1'b1;
          end
          7'b0000001: begin
`ifdef RV32M_EN
            ctrl.aluop = alu_ops_t'({1'b1, inst[14:12]});
            multicycle = 1'b1;
`else
            illegal = 1'b1;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl       = ctrl_defaults();
      multicycle = 1'b0;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction buffer plus registered decode stage (RV32M_EN via inst_decode)
module decode_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_inst,
  input  logic [31:0]                fetch_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_inst,
  output logic [31:0]                dec_pc,
  output control_signals_t           dec_ctrl,
  output logic                       dec_illegal,
  output logic                       dec_multicycle,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      buf_inst [DEPTH];
  logic [31:0]      buf_pc   [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             push, pop;
  control_signals_t head_ctrl, stage_ctrl;
  logic             head_illegal, head_multicycle;

  assign fetch_ready = (count < CNT_W'(DEPTH));
  assign push = fetch_valid && fetch_ready && !flush && !rst;
  assign pop  = (count != '0) && (!dec_valid || dec_ready) && !flush && !rst;

  inst_decode u_decode (
    .inst       (buf_inst[rptr]),
    .pc         (buf_pc[rptr]),
    .ctrl       (head_ctrl),
    .illegal    (head_illegal),
    .multicycle (head_multicycle)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wptr] <= fetch_inst;
      buf_pc[wptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Stage holds its contents until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dec_valid      <= 1'b0;
      dec_inst       <= NOP_INST;
      dec_pc         <= '0;
      stage_ctrl     <= ctrl_defaults();
      dec_illegal    <= 1'b0;
      dec_multicycle <= 1'b0;
    end else if (pop) begin
      dec_valid      <= 1'b1;
      dec_inst       <= buf_inst[rptr];
      dec_pc         <= buf_pc[rptr];
      stage_ctrl     <= head_ctrl;
      dec_illegal    <= head_illegal;
      dec_multicycle <= head_multicycle;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  always_comb begin
    dec_ctrl            = stage_ctrl;
    dec_ctrl.valid_rvfi = dec_valid && !dec_illegal;
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue (RV32M_EN selects mul expectations)
module tb_decode_queue;
  import rv32i_types::*;

  logic             clk = 1'b0;
  logic             rst, flush, fetch_valid, fetch_ready, dec_valid, dec_ready;
  logic [31:0]      fetch_inst, fetch_pc, dec_inst, dec_pc;
  control_signals_t dec_ctrl;
  logic             dec_illegal, dec_multicycle;
  logic [2:0]       count;

  decode_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_inst     (fetch_inst),
    .fetch_pc       (fetch_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_ctrl       (dec_ctrl),
    .dec_illegal    (dec_illegal),
    .dec_multicycle (dec_multicycle),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ill;
    logic        mc;
    alu_ops_t    aluop;
    logic        lr;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every handshake on the output stage is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_pc", dec_pc, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc", dec_pc, mon_e.pc);
        chk("out_inst", dec_inst, mon_e.inst);
        chk("out_illegal", 32'(dec_illegal), 32'(mon_e.ill));
        chk("out_multicycle", 32'(dec_multicycle), 32'(mon_e.mc));
        chk("out_aluop", 32'(dec_ctrl.aluop), 32'(mon_e.aluop));
        chk("out_load_reg", 32'(dec_ctrl.load_reg), 32'(mon_e.lr));
        chk("out_mem_read", 32'(dec_ctrl.mem_read), 32'(mon_e.mr));
        chk("out_mem_write", 32'(dec_ctrl.mem_write), 32'(mon_e.mw));
        chk("out_valid_rvfi", 32'(dec_ctrl.valid_rvfi), 32'(!mon_e.ill));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc, output logic acc);
    fetch_inst  = inst;
    fetch_pc    = pc;
    fetch_valid = 1'b1;
    acc         = fetch_ready;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic expect_push(input logic [31:0] inst, input logic [31:0] pc, input logic ill,
                             input logic mc, input alu_ops_t op, input logic lr,
                             input logic mr, input logic mw);
    exp_t e;
    e.inst = inst; e.pc = pc; e.ill = ill; e.mc = mc;
    e.aluop = op; e.lr = lr; e.mr = mr; e.mw = mw;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic ill,
                      input logic mc, input alu_ops_t op, input logic lr,
                      input logic mr, input logic mw);
    logic acc;
    expect_push(inst, pc, ill, mc, op, lr, mr, mw);
    offer(inst, pc, acc);
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    fetch_inst = '0; fetch_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_dec_inst", dec_inst, 32'h0000_0013);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_illegal", 32'(dec_illegal), 32'd0);
    chk("rst_multicycle", 32'(dec_multicycle), 32'd0);
    chk("rst_valid_rvfi", 32'(dec_ctrl.valid_rvfi), 32'd0);
    step();

    // addi x1,x0,5: two-edge latency into the stage
    send(32'h0050_0093, 32'h4000_0000, 1'b0, 1'b0, alu_add, 1'b1, 1'b0, 1'b0);
    chk("lat_after_1_edge", 32'(dec_valid), 32'd0);
    chk("lat_count_1", 32'(count), 32'd1);
    step();
    chk("lat_after_2_edges", 32'(dec_valid), 32'd1);
    chk("addi_alumux2", 32'(dec_ctrl.alumux2_sel), 32'(i_imm));
    dec_ready = 1'b1;
    wait_drain();

    // directed decode table
    send(32'h0000_0000, 32'h0000_0100, 1'b1, 1'b0, alu_add, 1'b0, 1'b0, 1'b0);
    send(32'h0000_B003, 32'h0000_0104, 1'b1, 1'b0, alu_add, 1'b0, 1'b0, 1'b0);
`ifdef RV32M_EN
    send(32'h0220_81B3, 32'h0000_0108, 1'b0, 1'b1, alu_mul, 1'b1, 1'b0, 1'b0);
`else
    send(32'h0220_81B3, 32'h0000_0108, 1'b1, 1'b0, alu_add, 1'b0, 1'b0, 1'b0);
`endif
    send(32'h4020_81B3, 32'h0000_010C, 1'b0, 1'b0, alu_sub, 1'b1, 1'b0, 1'b0);
    send(32'h4020_D1B3, 32'h0000_0110, 1'b0, 1'b0, alu_sra, 1'b1, 1'b0, 1'b0);
    send(32'h0001_2083, 32'h0000_0114, 1'b0, 1'b0, alu_add, 1'b1, 1'b1, 1'b0);
    send(32'h0011_2023, 32'h0000_0118, 1'b0, 1'b0, alu_add, 1'b0, 1'b0, 1'b1);
    send(32'h0000_2063, 32'h0000_011C, 1'b1, 1'b0, alu_add, 1'b0, 1'b0, 1'b0);
    send(32'h4020_91B3, 32'h0000_0120, 1'b1, 1'b0, alu_add, 1'b0, 1'b0, 1'b0);
    send(32'h4010_9093, 32'h0000_0124, 1'b1, 1'b0, alu_add, 1'b0, 1'b0, 1'b0);
    send(32'h4010_D093, 32'h0000_0128, 1'b0, 1'b0, alu_sra, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // backpressure: four buffered plus one staged, sixth refused
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5)
        expect_push(32'h0000_0093 | (i << 20), 32'h0000_2000 + 4 * i, 1'b0, 1'b0, alu_add,
                    1'b1, 1'b0, 1'b0);
      offer(32'h0000_0093 | (i << 20), 32'h0000_2000 + 4 * i, acc);
      chk("bp_accept", 32'(acc), 32'(i < 5));
    end
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("bp_staged_pc", dec_pc, 32'h0000_2000);
    repeat (3) step();
    chk("bp_hold_pc", dec_pc, 32'h0000_2000);
    chk("bp_hold_inst", dec_inst, 32'h0000_0093);
    dec_ready = 1'b1;
    wait_drain();

    // flush with three buffered and one staged; the offered instruction must vanish
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(32'h0000_0093, 32'h0000_3000 + 4 * i, acc);
    chk("fl_count_before", 32'(count), 32'd3);
    chk("fl_valid_before", 32'(dec_valid), 32'd1);
    flush = 1'b1;
    offer(32'h0070_0093, 32'h0000_3FF0, acc);
    flush = 1'b0;
    chk("fl_count_after", 32'(count), 32'd0);
    chk("fl_valid_after", 32'(dec_valid), 32'd0);
    dec_ready = 1'b1;
    repeat (4) step();
    chk("fl_nothing_appears", 32'(dec_valid), 32'd0);

    // continuous stream across pointer wrap
    pop_cyc.delete();
    for (int i = 0; i < 20; i++)
      send(32'h0000_0093 | (i << 20), 32'h0000_5000 + 4 * i, 1'b0, 1'b0, alu_add,
           1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("stream_pops", 32'(pop_cyc.size()), 32'd20);
    if (pop_cyc.size() == 20)
      chk("stream_span", 32'(pop_cyc[19] - pop_cyc[0]), 32'd19);

    // reset mid-stream discards everything
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(32'h0000_0093, 32'h0000_6000 + 4 * i, acc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 32'(dec_valid), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_inst", dec_inst, 32'h0000_0013);
    chk("mrst_fetch_ready", 32'(fetch_ready), 32'd1);
    dec_ready = 1'b1;
    repeat (3) step();
    send(32'h0050_0093, 32'h0000_7000, 1'b0, 1'b0, alu_add, 1'b1, 1'b0, 1'b0);
    wait_drain();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of instruction-buffer entries; power of two, at least 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  discard all buffered and staged instructions (redirect).
REQ-005 fetch_valid  input  1  fetch offers an instruction this cycle.
REQ-006 fetch_ready  output  1  queue accepts an instruction this cycle.
REQ-007 fetch_inst  input  32  raw RV32 instruction word.
REQ-008 fetch_pc  input  32  PC of fetch_inst.
REQ-009 dec_valid  output  1  decoded instruction staged on dec_* outputs.
REQ-010 dec_ready  input  1  consumer takes the staged instruction this cycle.
REQ-011 dec_inst  output  32  staged raw instruction.
REQ-012 dec_pc  output  32  staged PC.
REQ-013 dec_ctrl  output  control_signals_t  registered decoded control bundle.
REQ-014 dec_illegal  output  1  staged instruction is not a legal RV32I(M) encoding.
REQ-015 dec_multicycle  output  1  staged instruction is an M-extension op needing a multi-cycle ALU.
REQ-016 count  output  clog2(DEPTH+1)  current buffer occupancy, excluding the output stage.

Function
REQ-017 Push occurs when fetch_valid and fetch_ready are both high at a clock edge; pop-to-stage occurs when the buffer is non-empty and the stage is empty or dec_ready is high.
REQ-018 fetch_ready SHALL be high exactly when count < DEPTH, with no same-cycle pop credit.
REQ-019 A push into an empty buffer with an empty stage SHALL appear at dec_valid after the second following edge (2-cycle latency); the buffer is not bypassed.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-021 The stage SHALL hold dec_* stable while dec_valid is high and dec_ready is low.
REQ-022 Decode SHALL be combinational on the buffer head and registered into the stage: opcode, funct3, bits 30, 25 and 14 map to control_signals_t identically for lui, auipc, jal, jalr, branch, load, store, op_imm and op_reg.
REQ-023 load_align SHALL be derived from funct3 for loads; sr/add variants SHALL select via bit 30.
REQ-024 dec_illegal SHALL be set for: an unknown opcode; branch funct3 010 or 011; load funct3 011, 110 or 111; store funct3 above 010; op_reg funct7 other than 0000000, 0100000 (add/sr only) or 0000001; op_imm slli/srli/srai with a bad funct7.
REQ-025 When dec_illegal is set, dec_ctrl SHALL carry defaults with load_reg, mem_read and mem_write all 0.
REQ-026 dec_ctrl.valid_rvfi SHALL equal dec_valid AND NOT dec_illegal.
REQ-027 Flush SHALL empty the buffer and stage at the next edge; a push offered in the flush cycle SHALL be dropped; flush SHALL take priority over every push and pop.

Reset
REQ-028 On rst: pointers and count = 0, dec_valid = 0, dec_illegal = 0, dec_multicycle = 0, dec_inst = 0x00000013 (nop), dec_pc = 0, dec_ctrl = defaults; fetch_ready = 1 in the first cycle after reset.
REQ-029 Reset asserted mid-stream SHALL discard all entries; no partially staged instruction survives.

Configuration
REQ-030 Macro RV32M_EN: when defined, op_reg with funct7 0000001 SHALL decode to the mul/div ALU ops, with dec_multicycle = 1.
REQ-031 Without RV32M_EN, the same encodings SHALL raise dec_illegal, and dec_multicycle SHALL be tied to 0.

Structure
REQ-032 control_signals_t, the mux-select enums, the ALU/compare op enums, the funct3 unions and the opcode enum SHALL live in rv32i_types.
REQ-033 The decode logic SHALL live in a sub-module inst_decode (purely combinational, inst+pc in, ctrl/illegal/multicycle out); decode_queue adds the buffer and stage around it.

Verification
REQ-034 Push 0x00500093 (addi x1,x0,5) at PC 0x40000000 into an empty queue -> dec_valid is high 2 edges later; aluop = alu_add; alumux2_sel = i_imm; load_reg = 1; dec_illegal = 0.
REQ-035 DEPTH=4, hold dec_ready=0 and push 6 instructions -> count reaches 4, fetch_ready = 0, the 6th is not accepted; release dec_ready -> the accepted 5 drain in order by PC.
REQ-036 Push 0x00000000, then 0x0000B003 (load funct3 011) -> both staged with dec_illegal = 1, load_reg = 0, mem_write = 0, valid_rvfi = 0.
REQ-037 Push 0x022081B3 (mul x3,x1,x2) -> with RV32M_EN: aluop = alu_mul, dec_multicycle = 1; without it: dec_illegal = 1.
REQ-038 With 3 entries buffered plus a staged one, assert flush together with fetch_valid -> at the next edge count = 0, dec_valid = 0, and the offered instruction never appears.
REQ-039 Run a continuous push/pop stream of 20 instructions across pointer wrap -> output order and PC values match the input, with one instruction per cycle throughput.
